// File: rtl/dcr_pkg.sv
// Shared types and constants for the DCR fetch unit and its helpers.
//   fu_state_t    : fetch-unit FSM states
//   pcsrc_t       : next-PC select codes driven by the MCU
//   OP_BEQ/OP_BNE : opcodes that compare rs against rt (all others against zero)
//   GSE_*         : bit positions inside the {greater, less, equal} flag vector
//   branch_offset : sign-extended, word-scaled branch displacement
package dcr_pkg;

    typedef enum logic {
        FETCH = 1'b0,
        EXEC  = 1'b1
    } fu_state_t;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_JMP = 2'b10,
        PCSRC_REG = 2'b11
    } pcsrc_t;

    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam int GSE_G = 2;
    localparam int GSE_L = 1;
    localparam int GSE_E = 0;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/dcr_branch_cmp.sv
// Branch comparator: signed compare of rs against operand B, where B is rt
// for BEQ/BNE and zero for every other opcode (BGEZ, BLTZ, ...).
// Ports:
//   opcode  in  6   IR[31:26]
//   rs_data in  32  register-file rs read data
//   rt_data in  32  register-file rt read data
//   gse     out 3   {greater, less, equal}, exactly one bit set
module dcr_branch_cmp
    import dcr_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [5:0]            opcode,
    input  logic [DATA_WIDTH-1:0] rs_data,
    input  logic [DATA_WIDTH-1:0] rt_data,
    output logic [2:0]            gse
);

    logic [DATA_WIDTH-1:0] operand_b;

    always_comb begin
        operand_b = ((opcode == OP_BEQ) || (opcode == OP_BNE)) ? rt_data : '0;
        gse       = 3'b000;
        if ($signed(rs_data) > $signed(operand_b)) begin
            gse[GSE_G] = 1'b1;
        end else if ($signed(rs_data) < $signed(operand_b)) begin
            gse[GSE_L] = 1'b1;
        end else begin
            gse[GSE_E] = 1'b1;
        end
    end

endmodule

// File: rtl/dcr_fetch_unit.sv
// Fetch unit: owns PC, IR and a two-state FETCH/EXEC loop. Fetches over a
// req/valid handshake, exposes the IR fields and compare flags to the MCU,
// and applies the MCU's PCSrc on the commit cycle. No branch delay slot.
// Ports:
//   ClockInFU / ResetInFU           clock, synchronous active-high reset
//   ImemReqOutFU / ImemAddrOutFU    fetch request and address (= PC)
//   ImemDataInFU / ImemValidInFU    fetched word and its valid strobe
//   StallInFU                       datapath hold, honoured in EXEC
//   PCSrcInFU                       next-PC select from the MCU
//   RsDataInFU / RtDataInFU         register-file read data
//   OpcodeOutFU/RtOutFU/FuncOutFU   IR fields to the MCU
//   GSEOutFU                        {greater, less, equal} flags
//   InstrOutFU                      full IR
//   InstrValidOutFU                 commit strobe
//   PCOutFU / PCPlus4OutFU          PC of the IR and its link value
module dcr_fetch_unit
    import dcr_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    // Field slicing below assumes a 32-bit instruction word; only 32 is supported.
    parameter int          DATA_WIDTH   = 32
) (
    input  logic                  ClockInFU,
    input  logic                  ResetInFU,
    output logic                  ImemReqOutFU,
    output logic [DATA_WIDTH-1:0] ImemAddrOutFU,
    input  logic [DATA_WIDTH-1:0] ImemDataInFU,
    input  logic                  ImemValidInFU,
    input  logic                  StallInFU,
    input  logic [1:0]            PCSrcInFU,
    input  logic [DATA_WIDTH-1:0] RsDataInFU,
    input  logic [DATA_WIDTH-1:0] RtDataInFU,
    output logic [5:0]            OpcodeOutFU,
    output logic [4:0]            RtOutFU,
    output logic [5:0]            FuncOutFU,
    output logic [2:0]            GSEOutFU,
    output logic [DATA_WIDTH-1:0] InstrOutFU,
    output logic                  InstrValidOutFU,
    output logic [DATA_WIDTH-1:0] PCOutFU,
    output logic [DATA_WIDTH-1:0] PCPlus4OutFU
);

    fu_state_t             state_reg;
    logic [DATA_WIDTH-1:0] pc_reg;
    logic [DATA_WIDTH-1:0] ir_reg;

    logic [DATA_WIDTH-1:0] pc_plus4;
    logic [DATA_WIDTH-1:0] pc_next;
    logic [2:0]            gse_raw;
    logic                  exec_active;
    logic                  commit;

    // Handshake and commit outputs are qualified by the reset input so that
    // nothing is requested or retired during a reset cycle, whatever state
    // the FSM happened to be in.
    assign exec_active = (state_reg == EXEC) && !ResetInFU;
    assign commit      = exec_active && !StallInFU;

    assign pc_plus4 = pc_reg + 32'd4;

    always_comb begin
        pc_next = pc_plus4;
        case (pcsrc_t'(PCSrcInFU))
            PCSRC_SEQ: pc_next = pc_plus4;
            PCSRC_BR:  pc_next = pc_plus4 + branch_offset(ir_reg[15:0]);
            PCSRC_JMP: pc_next = {pc_plus4[31:28], ir_reg[25:0], 2'b00};
            PCSRC_REG: pc_next = {RsDataInFU[31:2], 2'b00};
            default:   pc_next = pc_plus4;
        endcase
    end

    always_ff @(posedge ClockInFU) begin
        if (ResetInFU) begin
            state_reg <= FETCH;
            pc_reg    <= RESET_VECTOR;
            ir_reg    <= '0;
        end else begin
            case (state_reg)
                FETCH: begin
                    if (ImemValidInFU) begin
                        ir_reg    <= ImemDataInFU;
                        state_reg <= EXEC;
                    end
                end
                EXEC: begin
                    if (!StallInFU) begin
                        pc_reg    <= pc_next;
                        state_reg <= FETCH;
                    end
                end
                default: state_reg <= FETCH;
            endcase
        end
    end

    dcr_branch_cmp #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_branch_cmp (
        .opcode  (ir_reg[31:26]),
        .rs_data (RsDataInFU),
        .rt_data (RtDataInFU),
        .gse     (gse_raw)
    );

    // Flags are only meaningful while the MCU decodes in EXEC.
    for (genvar gi = 0; gi < 3; gi++) begin : g_gse
        assign GSEOutFU[gi] = gse_raw[gi] & exec_active;
    end

    assign ImemReqOutFU    = (state_reg == FETCH) && !ResetInFU;
    assign ImemAddrOutFU   = pc_reg;
    assign OpcodeOutFU     = ir_reg[31:26];
    assign RtOutFU         = ir_reg[20:16];
    assign FuncOutFU       = ir_reg[5:0];
    assign InstrOutFU      = ir_reg;
    assign InstrValidOutFU = commit;
    assign PCOutFU         = pc_reg;
    assign PCPlus4OutFU    = pc_plus4;

endmodule
